tree_router_rr: RTL
===================

# tree_router_rr

Parametrised, clocked successor of the binary tree router: one parent port and NUM_CH child ports, each input buffered in its own FIFO. Every output has an independent round-robin arbiter, so unrelated flows proceed in parallel. Back-pressure replaces the overflow stop, and packets with no valid route are dropped and counted. The block sits at every internal node of the NoC tree; the top node is the same module with IS_ROOT=1.

## Interface
- NUM_CH, 2: number of child ports (≥2)
- WIDTH_PACK, 20: packet width
- WIDTH_ADD, 5: address field width
- DEPTH, 4: entries per input FIFO (≥2)
- LEFT_MIN, 1: lowest PE address in this subtree
- CHILD_SPAN, 7: addresses per child; child i covers [LEFT_MIN+i·CHILD_SPAN, LEFT_MIN+(i+1)·CHILD_SPAN−1]; RIGHT_MAX = LEFT_MIN+NUM_CH·CHILD_SPAN−1 (derived)
- IS_ROOT, 0: 1 = no parent; parent ports tied off, out-of-range packets dropped
- CNT_W, 16: drop counter width
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- p_in_data / p_in_valid / p_in_ready  in/in/out  WIDTH_PACK/1/1  from parent
- p_out_data / p_out_valid / p_out_ready  out/out/in  WIDTH_PACK/1/1  to parent
- ch_in_data / ch_in_valid / ch_in_ready  in/in/out  [NUM_CH][WIDTH_PACK] / NUM_CH / NUM_CH  from children
- ch_out_data / ch_out_valid / ch_out_ready  out/out/in  [NUM_CH][WIDTH_PACK] / NUM_CH / NUM_CH  to children
- drop_cnt  out  CNT_W  unroutable packets, saturating

## Operation
- Packet: {type[1:0], sender[4:0], receiver[4:0], data[7:0]}; route on receiver (bits 12:8).
- Input side: FIFO push on valid&ready; ready = !full (no push-through-full, even with a same-cycle pop).
- Route of FIFO head, combinational:
  - parent input: child i covering receiver; receiver outside [LEFT_MIN, RIGHT_MAX] → drop.
  - child input: receiver outside range → parent (IS_ROOT=1: drop); else covering child, including the source child (U-turn legal).
- Drop: head popped in one cycle with no output request; drop_cnt += 1, saturates at all-ones.
- Per output: arbiter over NUM_CH+1 inputs in order parent, ch0..ch(N−1); round-robin, last-granted input lowest priority next; priority pointer advances only on a grant. Each input requests exactly one output, so no input is granted twice.
- Output register per port: loaded on grant when empty or draining the same cycle; data held stable while valid&!ready.
- Per-port ordering preserved for every input→output pair.

## Timing
- Reset (async assert, sync release): all FIFOs empty, all *_out_valid=0, all *_in_ready=1, arbiter pointers → parent, drop_cnt=0. A mid-packet reset discards buffered data, no partial outputs.
- Latency: input accepted at edge N → FIFO head at N+1 → granted into output register at edge N+1 → out_valid high after N+1; minimum 2 cycles input to output.
- Throughput: 1 packet/cycle per output under continuous ready; 1/cycle per input.
- FIFO wrap at DEPTH via modulo pointers with separate count; full and empty both correct at all occupancy values.
- Simultaneous push/pop on a non-full FIFO: count unchanged.

## Structure
- Package router_pkg: packet field positions, packet_t struct, function get_recv_addr, address-width constant.
- Sub-module tree_router_fifo (DEPTH, WIDTH_PACK; push/pop/full/empty/head), instanced NUM_CH+1 times; arbiter logic in a generate loop over outputs.

## Test plan
- NUM_CH=2, parent sends receiver=9 → appears on ch_out[1] 2 cycles later; receiver=3 → ch_out[0].
- ch0 sends receiver=20 → p_out; with IS_ROOT=1 the same packet → drop_cnt=1, no output valid.
- Parent, ch0 and ch1 all target ch1 continuously with ready=1 → grants rotate p, ch0, ch1, p, ...; each input gets exactly 1 of every 3 packets.
- ch_out_ready[0]=0, push 6 packets to ch0 target → out register + 4 FIFO entries fill, p_in_ready=0 after the 5th push, 6th held; raise ready → all 6 delivered in order.
- ch0→ch1 and ch1→ch0 simultaneously → both delivered in the same cycle, no serialisation.
- Assert rst_n low with 3 packets buffered → outputs drop valid immediately, ready=1; no stale packet appears after release.

Source files
------------

// File: rtl/router_pkg.sv
// Packet layout and routing helpers shared by the tree router blocks.
package router_pkg;

    localparam int PACK_W   = 20;  // {type[1:0], sender[4:0], receiver[4:0], data[7:0]}
    localparam int ADDR_W   = 5;   // PE address width
    localparam int RECV_LSB = 8;   // receiver field starts at bit 8

    typedef struct packed {
        logic [1:0]        ptype;
        logic [ADDR_W-1:0] sender;
        logic [ADDR_W-1:0] receiver;
        logic [7:0]        data;
    } packet_t;

    // Receiver address of a packet; the routing decision is based on it alone.
    function automatic logic [ADDR_W-1:0] get_recv_addr(input logic [PACK_W-1:0] pkt);
        packet_t p;
        p = packet_t'(pkt);
        return p.receiver;
    endfunction

endpackage

// File: rtl/tree_router_fifo.sv
// Input buffer: circular FIFO with modulo pointers and a separate occupancy count.
module tree_router_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // A push is refused when full even if a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are meaningless while empty so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/tree_router_rr.sv
// Tree NoC node: buffered parent/child inputs, per-output round-robin arbiters,
// registered outputs, and a saturating counter of dropped (unroutable) packets.
//
// Handshake: a word moves across any port on a rising edge where valid and
// ready are both high; a source holds valid and data stable until that edge,
// and ready never depends combinationally on valid.
module tree_router_rr
    import router_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int WIDTH_PACK = 20,
    parameter int WIDTH_ADD  = 5,
    parameter int DEPTH      = 4,
    parameter int LEFT_MIN   = 1,
    parameter int CHILD_SPAN = 7,
    parameter int IS_ROOT    = 0,
    parameter int CNT_W      = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [WIDTH_PACK-1:0]             p_in_data,
    input  logic                              p_in_valid,
    output logic                              p_in_ready,
    output logic [WIDTH_PACK-1:0]             p_out_data,
    output logic                              p_out_valid,
    input  logic                              p_out_ready,
    input  logic [NUM_CH-1:0][WIDTH_PACK-1:0] ch_in_data,
    input  logic [NUM_CH-1:0]                 ch_in_valid,
    output logic [NUM_CH-1:0]                 ch_in_ready,
    output logic [NUM_CH-1:0][WIDTH_PACK-1:0] ch_out_data,
    output logic [NUM_CH-1:0]                 ch_out_valid,
    input  logic [NUM_CH-1:0]                 ch_out_ready,
    output logic [CNT_W-1:0]                  drop_cnt
);

    // Port index 0 is the parent, 1..NUM_CH are the children (inputs and outputs alike).
    localparam int NUM_OUT   = NUM_CH + 1;
    localparam int IW        = $clog2(NUM_OUT);
    localparam int DW        = $clog2(NUM_OUT + 1);
    localparam int RIGHT_MAX = LEFT_MIN + NUM_CH * CHILD_SPAN - 1;

    logic [WIDTH_PACK-1:0] in_data  [NUM_OUT];
    logic [NUM_OUT-1:0]    in_push;
    logic [NUM_OUT-1:0]    fifo_full;
    logic [NUM_OUT-1:0]    fifo_empty;
    logic [NUM_OUT-1:0]    fifo_pop;
    logic [WIDTH_PACK-1:0] head     [NUM_OUT];
    logic [IW-1:0]         dest     [NUM_OUT];
    logic [NUM_OUT-1:0]    drop;
    logic [NUM_OUT-1:0]    req      [NUM_OUT];
    logic [NUM_OUT-1:0]    gnt      [NUM_OUT];
    logic [NUM_OUT-1:0]    out_ready;
    logic [NUM_OUT-1:0]    out_valid;
    logic [WIDTH_PACK-1:0] out_data [NUM_OUT];
    logic [DW-1:0]         n_drop;
    logic [CNT_W:0]        cnt_sum;

    // Gather input ports into index-ordered arrays; the root has no parent input.
    always_comb begin
        in_data[0]   = p_in_data;
        in_push[0]   = (IS_ROOT == 0) && p_in_valid && !fifo_full[0];
        out_ready[0] = p_out_ready;
        for (int c = 0; c < NUM_CH; c++) begin
            in_data[c+1]   = ch_in_data[c];
            in_push[c+1]   = ch_in_valid[c] && !fifo_full[c+1];
            out_ready[c+1] = ch_out_ready[c];
        end
    end

    assign p_in_ready = (IS_ROOT == 0) && !fifo_full[0];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_fifo
            tree_router_fifo #(
                .DEPTH (DEPTH),
                .WIDTH (WIDTH_PACK)
            ) u_fifo (
                .clk   (clk),
                .rst_n (rst_n),
                .push  (in_push[gi]),
                .pop   (fifo_pop[gi]),
                .din   (in_data[gi]),
                .full  (fifo_full[gi]),
                .empty (fifo_empty[gi]),
                .head  (head[gi])
            );
        end
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch_io
            assign ch_in_ready[gi]  = !fifo_full[gi+1];
            assign ch_out_valid[gi] = out_valid[gi+1];
            assign ch_out_data[gi]  = out_data[gi+1];
        end
    endgenerate

    // Route each FIFO head: covering child if in range, else parent (child inputs
    // of a non-root node) or drop. Each valid head requests exactly one output.
    always_comb begin
        for (int i = 0; i < NUM_OUT; i++) begin
            logic [WIDTH_ADD-1:0] recv;
            int                   r;
            recv    = get_recv_addr(head[i][PACK_W-1:0]);
            r       = int'(recv);
            dest[i] = '0;
            drop[i] = 1'b0;
            if (r >= LEFT_MIN && r <= RIGHT_MAX) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (r >= LEFT_MIN + c * CHILD_SPAN && r <= LEFT_MIN + (c + 1) * CHILD_SPAN - 1)
                        dest[i] = IW'(c + 1);
                end
            end else if (i == 0 || IS_ROOT != 0) begin
                drop[i] = 1'b1;
            end
            for (int o = 0; o < NUM_OUT; o++)
                req[o][i] = !fifo_empty[i] && !drop[i] && (dest[i] == IW'(o));
        end
    end

    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_out
            logic [IW-1:0]         ptr;
            logic [IW-1:0]         gidx;
            logic [NUM_OUT-1:0]    g;
            logic                  any;
            logic                  load_ok;
            logic [WIDTH_PACK-1:0] gdat;
            logic                  vld;
            logic [WIDTH_PACK-1:0] dat;

            // Round-robin search starting at ptr; only grant when the register can accept.
            always_comb begin
                int idx;
                g       = '0;
                any     = 1'b0;
                gidx    = ptr;
                gdat    = head[0];
                idx     = 0;
                load_ok = !vld || out_ready[gi];
                for (int k = 0; k < NUM_OUT; k++) begin
                    idx = int'(ptr) + k;
                    if (idx >= NUM_OUT) idx = idx - NUM_OUT;
                    if (!any && load_ok && req[gi][idx]) begin
                        any    = 1'b1;
                        g[idx] = 1'b1;
                        gidx   = IW'(idx);
                        gdat   = head[idx];
                    end
                end
            end

            // Output register and priority pointer; pointer moves past the winner only on a grant.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld <= 1'b0;
                    dat <= '0;
                    ptr <= '0;
                end else if (any) begin
                    vld <= 1'b1;
                    dat <= gdat;
                    ptr <= (gidx == IW'(NUM_OUT - 1)) ? '0 : gidx + IW'(1);
                end else if (out_ready[gi]) begin
                    vld <= 1'b0;
                end
            end

            assign gnt[gi]      = g;
            assign out_valid[gi] = vld;
            assign out_data[gi]  = dat;
        end
    endgenerate

    assign p_out_valid = (IS_ROOT == 0) && out_valid[0];
    assign p_out_data  = out_data[0];

    // Pop a head when its output grants it, or unconditionally when it is unroutable.
    always_comb begin
        n_drop = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            fifo_pop[i] = !fifo_empty[i] && drop[i];
            if (!fifo_empty[i] && drop[i]) n_drop = n_drop + DW'(1);
            for (int o = 0; o < NUM_OUT; o++)
                if (gnt[o][i]) fifo_pop[i] = 1'b1;
        end
        cnt_sum = {1'b0, drop_cnt} + (CNT_W + 1)'(n_drop);
    end

    // Saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt <= '0;
        else        drop_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end

endmodule
